seq_bit_serializer: RTL
=======================

Name: seq_bit_serializer

Overview:
- Upstream feeder for the serial pattern detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `seq_out`, which drives the detector's `seq` input.
- Holds one word in flight plus one pending word, so back-to-back words stream with no idle gap.
- Provides a frame marker and a sent-word counter for debug.

Parameters:
- WIDTH, 8: word width in bits (legal range 2..32).
- MSB_FIRST, 1: 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
- IDLE_BIT, 0: value driven on `seq_out` while no word is being shifted.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- in_data, input, WIDTH: parallel word to serialize.
- in_valid, input, 1: `in_data` is valid.
- in_ready, output, 1: block can accept a word this cycle.
- seq_out, output, 1: serial bit stream to the detector.
- bit_valid, output, 1: `seq_out` carries a data bit (not idle fill).
- frame_start, output, 1: high during the first bit of each word.
- busy, output, 1: shifting is in progress or a word is pending.
- words_sent, output, 16: count of completely shifted words.

Behaviour:
- Internal state:
  - FSM states IDLE and SHIFT.
  - `shreg[WIDTH]`: word being shifted.
  - `bit_cnt`: `$clog2(WIDTH)` bits.
  - `pend_data[WIDTH]` and `pend_full`: one-entry pending buffer.
- Reset (async; outputs valid while `rst` is high):
  - State = IDLE, `bit_cnt` = 0, `pend_full` = 0, `words_sent` = 0.
  - Outputs: `seq_out` = IDLE_BIT, `bit_valid` = 0, `frame_start` = 0, `busy` = 0, `in_ready` = 1.
  - Reset asserted mid-word discards both the active word and the pending word. No partial bits appear after release.
- Handshake:
  - `in_ready` = !pend_full. It is a function of flops only and never depends on `in_valid`.
  - A transfer occurs on a rising edge where `in_valid && in_ready`.
  - The source must hold `in_data` stable while `in_valid` is high and `in_ready` is low.
- Outputs (decoded from flops only, no combinational path from inputs):
  - `bit_valid` = (state == SHIFT).
  - `seq_out` = IDLE_BIT in IDLE.
  - In SHIFT, `seq_out` = `shreg[WIDTH-1]` if MSB_FIRST, else `shreg[0]`.
  - `frame_start` = (state == SHIFT && bit_cnt == 0).
  - `busy` = (state == SHIFT) || pend_full.
- Transitions at each rising edge:
  - IDLE, transfer: `shreg` <= `in_data`, `bit_cnt` <= 0, state <= SHIFT. The first bit is visible in the cycle after the accepting edge (latency 1).
  - IDLE, no transfer: hold. `pend_full` is never 1 in IDLE.
  - SHIFT, `bit_cnt` < WIDTH-1:
    - Shift `shreg` by one toward the output end. Zero-fill is don't-care.
    - `bit_cnt` <= `bit_cnt` + 1.
    - A transfer writes the word into `pend_data` and sets `pend_full` <= 1.
  - SHIFT, `bit_cnt` == WIDTH-1 (last bit): `words_sent` increments.
    - If `pend_full`: `shreg` <= `pend_data`, `pend_full` <= 0, `bit_cnt` <= 0, stay in SHIFT. No transfer is possible this edge because `in_ready` = 0.
    - Else, if a transfer occurs: `shreg` <= `in_data` directly (bypass), `bit_cnt` <= 0, stay in SHIFT.
    - Else: state <= IDLE.
- Continuous streaming: `bit_valid` stays high across word boundaries with zero gap whenever the next word is available by the last-bit edge.
- `words_sent`: 16-bit and wraps 16'hFFFF -> 16'h0000. It counts only fully shifted words, never words discarded by reset.
- Each word's bits appear on exactly WIDTH consecutive cycles. No bit is repeated or dropped.

Test Plan:
1. WIDTH=8, MSB_FIRST=1: send 8'b1101_1000 once -> `seq_out` = 1,1,0,1,1,0,0,0 on 8 consecutive cycles starting 1 cycle after the accept. `frame_start` high on the first bit only. Then IDLE, `seq_out` = 0, `words_sent` = 1.
2. Hold `in_valid` = 1 with words 8'hD8, 8'h6C, 8'hFF -> 24 contiguous `bit_valid` cycles. `in_ready` drops after the second word is pending and rises the cycle after each reload. `frame_start` pulses at cycles 1, 9 and 17. `words_sent` = 3.
3. Present a word exactly on the last-bit edge with the pending buffer empty -> bypass load. Next bit is the new word's first bit with no gap, and `pend_full` stays 0.
4. MSB_FIRST=0, word 8'b0000_1011 -> `seq_out` = 1,1,0,1,0,0,0,0.
5. Assert `rst` at bit 4 with a word pending -> same cycle: `seq_out` = IDLE_BIT, `bit_valid` = 0, `in_ready` = 1, `busy` = 0, `words_sent` = 0. After release, no residual bits are emitted.
6. Preload `words_sent` to 16'hFFFF (via 65535 words or a forced value) and send one more word -> reads 16'h0000.

Source files
------------

// File: rtl/seq_bit_serializer_if.sv
// Handshake and serial-output bundle for seq_bit_serializer.
// master: the word source / observer side. slave: the serializer itself.
interface seq_bit_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             seq_out;
   logic             bit_valid;
   logic             frame_start;
   logic             busy;
   logic [15:0]      words_sent;

   modport master (
      output in_data, in_valid,
      input  in_ready, seq_out, bit_valid, frame_start, busy, words_sent
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, seq_out, bit_valid, frame_start, busy, words_sent
   );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the serial pattern detector.
// One word shifts out while a second waits in a one-entry pending buffer,
// so back-to-back words stream with no idle bit between them. When the
// pending buffer is empty, a word arriving on the last-bit edge is loaded
// straight into the shift register.
module seq_bit_serializer #(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   seq_bit_serializer_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [WIDTH-1:0] r_pend_data;
   logic             r_pend_full;
   logic [15:0]      r_words_sent;

   logic             w_xfer;
   logic             w_last;
   logic             w_shifting;
   logic [WIDTH-1:0] w_shreg_next;

   // Ready depends only on the pending flop, never on in_valid.
   assign w_xfer     = bus.in_valid && !r_pend_full;
   assign w_shifting = (r_state == S_SHIFT);
   assign w_last     = (r_bit_cnt == LAST_CNT);

   // Move the next bit toward the output end; the vacated bit is don't-care.
   assign w_shreg_next = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                   : {1'b0, r_shreg[WIDTH-1:1]};

   // Control state: FSM, bit counter, pending flag and word counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_bit_cnt    <= '0;
         r_pend_full  <= 1'b0;
         r_words_sent <= 16'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  r_state   <= S_SHIFT;
                  r_bit_cnt <= '0;
               end
            end
            default: begin
               if (!w_last) begin
                  r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  if (w_xfer) begin
                     r_pend_full <= 1'b1;
                  end
               end else begin
                  r_words_sent <= r_words_sent + 16'd1;
                  if (r_pend_full) begin
                     r_pend_full <= 1'b0;
                     r_bit_cnt   <= '0;
                  end else if (w_xfer) begin
                     r_bit_cnt   <= '0;
                  end else begin
                     r_state     <= S_IDLE;
                  end
               end
            end
         endcase
      end
   end

   // Data path: shift register and pending word carry no reset.
   always_ff @(posedge clk) begin
      if (!w_shifting) begin
         if (w_xfer) begin
            r_shreg <= bus.in_data;
         end
      end else if (!w_last) begin
         r_shreg <= w_shreg_next;
         if (w_xfer) begin
            r_pend_data <= bus.in_data;
         end
      end else begin
         if (r_pend_full) begin
            r_shreg <= r_pend_data;
         end else if (w_xfer) begin
            r_shreg <= bus.in_data;
         end
      end
   end

   assign bus.in_ready    = !r_pend_full;
   assign bus.bit_valid   = w_shifting;
   assign bus.seq_out     = w_shifting ? (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0])
                                       : IDLE_BIT;
   assign bus.frame_start = w_shifting && (r_bit_cnt == '0);
   assign bus.busy        = w_shifting || r_pend_full;
   assign bus.words_sent  = r_words_sent;

endmodule
